// File: rtl/mips_exec_ctrl.sv
// Single-cycle MIPS main decoder, ALU control decoder and ALU; no backpressure (purely per-instruction).
// Latency: ALU_result/zero combinational, or one clock edge when ALU_RESULT_REG_EN is defined.
module mips_exec_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] imm_ext,
  output logic              RegDst,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemtoReg,
  output logic [1:0]        ALUop,
  output logic              MemWrite,
  output logic              ALUsrc,
  output logic              RegWrite,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ALU_result,
  output logic              zero
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  ctrl_t             ctrl;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_comb;

  // Reset masks every strobe so nothing writes or branches during reset.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (opcode)
        OP_RTYPE: ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
        OP_LW:    ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        OP_SW:    ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        OP_BEQ:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        OP_ADDI:  ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        default:  ctrl = '0;
      endcase
    end
  end

  assign RegDst   = ctrl.reg_dst;
  assign ALUsrc   = ctrl.alu_src;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign ALUop    = ctrl.alu_op;

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ctrl.alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b11: alu_ctrl = ALU_ADD;
      default: begin
        case (funct)
          6'b100000: alu_ctrl = ALU_ADD;
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b101010: alu_ctrl = ALU_SLT;
          6'b100111: alu_ctrl = ALU_NOR;
          default:   alu_ctrl = ALU_BAD;
        endcase
      end
    endcase
  end

  assign alu_b = ctrl.alu_src ? imm_ext : read_data2;

  always_comb begin
    alu_comb = '0;
    case (alu_ctrl)
      ALU_AND: alu_comb = read_data1 & alu_b;
      ALU_OR:  alu_comb = read_data1 | alu_b;
      ALU_ADD: alu_comb = read_data1 + alu_b;
      ALU_SUB: alu_comb = read_data1 - alu_b;
      ALU_SLT: alu_comb = ($signed(read_data1) < $signed(alu_b)) ? DATA_W'(1) : '0;
      ALU_NOR: alu_comb = ~(read_data1 | alu_b);
      default: alu_comb = '0;
    endcase
  end

`ifdef ALU_RESULT_REG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ALU_result <= '0;
      zero       <= 1'b1;
    end else begin
      ALU_result <= alu_comb;
      zero       <= ~|alu_comb;
    end
  end
`else
  assign ALU_result = alu_comb;
  assign zero       = ~|alu_comb;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Vector table for the exec slice; ALU results flow through a scoreboard queue so the
// same table covers both the combinational and the ALU_RESULT_REG_EN build.
module tb_mips_exec_ctrl;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm_ext;
  logic        RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite;
  logic [1:0]  ALUop;
  logic [3:0]  alu_ctrl;
  logic [31:0] ALU_result;
  logic        zero;

  mips_exec_ctrl #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .read_data1(read_data1), .read_data2(read_data2), .imm_ext(imm_ext),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .ALUop(ALUop), .MemWrite(MemWrite), .ALUsrc(ALUsrc), .RegWrite(RegWrite),
    .alu_ctrl(alu_ctrl), .ALU_result(ALU_result), .zero(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [8:0]  ctrl;   // RegDst,ALUsrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop
    logic [3:0]  ac;
    logic [31:0] res;    // combinational ALU result
  } vec_t;

  localparam logic [8:0] C_R    = 9'b100100010;
  localparam logic [8:0] C_LW   = 9'b011110000;
  localparam logic [8:0] C_SW   = 9'b010001000;
  localparam logic [8:0] C_BEQ  = 9'b000000101;
  localparam logic [8:0] C_ADDI = 9'b010100000;
  localparam logic [8:0] C_NOP  = 9'b000000000;

  localparam int NV = 17;
  vec_t        tbl[NV];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [8:0] ctrl_act();
    return {RegDst, ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, check decode immediately, then retire the ALU result from the queue.
  task automatic apply(input int idx);
    vec_t        v;
    logic [31:0] e;
    v = tbl[idx];
    @(negedge clock);
    reset = v.rst; opcode = v.op; funct = v.fn;
    read_data1 = v.a; read_data2 = v.b; imm_ext = v.imm;
`ifdef ALU_RESULT_REG_EN
    exp_q.push_back(v.rst ? 32'h0 : v.res);
`else
    exp_q.push_back(v.res);
`endif
    #1;
    chk($sformatf("ctrl[%0d]", idx), 32'(ctrl_act()), 32'(v.ctrl));
    chk($sformatf("alu_ctrl[%0d]", idx), 32'(alu_ctrl), 32'(v.ac));
`ifdef ALU_RESULT_REG_EN
    @(posedge clock); #1;
`endif
    if (exp_q.size() == 0) begin
      chk($sformatf("queue_empty[%0d]", idx), 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("result[%0d]", idx), ALU_result, e);
      chk($sformatf("zero[%0d]", idx), 32'(zero), 32'(e == 32'h0));
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 6'b000000, 6'b100000, 32'd5, 32'd7, 32'h0, C_R, 4'b0010, 32'd12};
    tbl[1]  = '{1'b0, 6'b000000, 6'b100010, 32'd3, 32'd5, 32'h0, C_R, 4'b0110, 32'hFFFFFFFE};
    tbl[2]  = '{1'b0, 6'b000000, 6'b101010, 32'd3, 32'd5, 32'h0, C_R, 4'b0111, 32'd1};
    tbl[3]  = '{1'b0, 6'b000000, 6'b101010, 32'h80000000, 32'd1, 32'h0, C_R, 4'b0111, 32'd1};
    tbl[4]  = '{1'b0, 6'b000000, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'h0, C_R, 4'b0111, 32'd0};
    tbl[5]  = '{1'b0, 6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd1, 32'h0, C_R, 4'b0010, 32'd0};
    tbl[6]  = '{1'b0, 6'b000000, 6'b100100, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, C_R, 4'b0000, 32'h00F0000F};
    tbl[7]  = '{1'b0, 6'b000000, 6'b100101, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, C_R, 4'b0001, 32'hFFF00FFF};
    tbl[8]  = '{1'b0, 6'b000000, 6'b100111, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, C_R, 4'b1100, 32'h000FF000};
    tbl[9]  = '{1'b0, 6'b000000, 6'b000001, 32'd5, 32'd7, 32'h0, C_R, 4'b1111, 32'd0};
    tbl[10] = '{1'b0, 6'b100011, 6'b100010, 32'h10, 32'd123, 32'hFFFFFFFC, C_LW, 4'b0010, 32'h0C};
    tbl[11] = '{1'b0, 6'b101011, 6'b000000, 32'h10, 32'd55, 32'h8, C_SW, 4'b0010, 32'h18};
    tbl[12] = '{1'b0, 6'b000100, 6'b100000, 32'd9, 32'd9, 32'd100, C_BEQ, 4'b0110, 32'd0};
    tbl[13] = '{1'b0, 6'b000100, 6'b100000, 32'd9, 32'd8, 32'd100, C_BEQ, 4'b0110, 32'd1};
    tbl[14] = '{1'b0, 6'b001000, 6'b100010, 32'd100, 32'd3, 32'hFFFFFFFF, C_ADDI, 4'b0010, 32'd99};
    tbl[15] = '{1'b0, 6'b111111, 6'b100010, 32'd5, 32'd7, 32'd1000, C_NOP, 4'b0010, 32'd12};
    tbl[16] = '{1'b1, 6'b000000, 6'b100010, 32'd3, 32'd5, 32'd1000, C_NOP, 4'b0010, 32'd8};

    reset = 1'b1; opcode = 6'b000000; funct = 6'b100000;
    read_data1 = 32'd5; read_data2 = 32'd7; imm_ext = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ctrl", 32'(ctrl_act()), 32'(C_NOP));
    chk("reset_regwrite", 32'(RegWrite), 32'd0);
`ifdef ALU_RESULT_REG_EN
    chk("reset_result", ALU_result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
`endif

    for (int i = 0; i < NV; i++) apply(i);

`ifdef ALU_RESULT_REG_EN
    // Result must hold its old value until the edge, then load; a reset edge clears it.
    @(negedge clock);
    reset = 1'b0; opcode = 6'b000000; funct = 6'b100000;
    read_data1 = 32'd5; read_data2 = 32'd7;
    #1;
    chk("hold_before_edge", ALU_result, 32'd0);
    @(posedge clock); #1;
    chk("load_after_edge", ALU_result, 32'd12);
    chk("load_zero", 32'(zero), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_edge_result", ALU_result, 32'd0);
    chk("reset_edge_zero", 32'(zero), 32'd1);
`else
    // Operand changes propagate in the same cycle without waiting for an edge.
    @(negedge clock);
    reset = 1'b0; opcode = 6'b000000; funct = 6'b100000;
    read_data1 = 32'd5; read_data2 = 32'd7;
    #1;
    chk("comb_add", ALU_result, 32'd12);
    read_data2 = 32'hFFFFFFFB;
    #1;
    chk("comb_wrap", ALU_result, 32'd0);
    chk("comb_zero", 32'(zero), 32'd1);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
